// File: rtl/number_bcd_module.sv
// rtl/number_bcd_module.sv - 10-bit binary to 3-digit BCD, shift-add-3 over 10 cycles.
// Optional NUMBER_BCD_CLAMP_EN: out-of-range inputs show 999 instead of the FFF blank code.
module number_bcd_module (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Start_Sig,
  input  logic [9:0]  Binary_Sig,
  output logic [11:0] Number_Sig,
  output logic        Done_Sig,
  output logic        Busy_Sig,
  output logic        Ovf_Sig
);

`ifdef NUMBER_BCD_CLAMP_EN
  localparam logic [11:0] OVF_CODE = 12'h999;
`else
  localparam logic [11:0] OVF_CODE = 12'hFFF;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [21:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [11:0] number_q, number_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ovf_out_q, ovf_out_d;
  logic [21:0] adj;

  // Working register is {hundreds, tens, ones, binary}; digits are corrected on pre-add values.
  always_comb begin
    adj = work_q;
    if (work_q[13:10] >= 4'd5) adj[13:10] = work_q[13:10] + 4'd3;
    if (work_q[17:14] >= 4'd5) adj[17:14] = work_q[17:14] + 4'd3;
    if (work_q[21:18] >= 4'd5) adj[21:18] = work_q[21:18] + 4'd3;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start_Sig) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd9) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    work_d    = work_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    number_d  = number_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      IDLE: begin
        if (Start_Sig) begin
          work_d = {12'b0, Binary_Sig};
          ovf_d  = (Binary_Sig > 10'd999);
          cnt_d  = 4'd0;
          busy_d = 1'b1;
        end
      end
      SHIFT: begin
        work_d = {adj[20:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
      end
      DONE: begin
        number_d  = ovf_q ? OVF_CODE : work_q[21:10];
        ovf_out_d = ovf_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      work_q    <= 22'd0;
      cnt_q     <= 4'd0;
      ovf_q     <= 1'b0;
      number_q  <= 12'h000;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      number_q  <= number_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign Number_Sig = number_q;
  assign Done_Sig   = done_q;
  assign Busy_Sig   = busy_q;
  assign Ovf_Sig    = ovf_out_q;

endmodule
